// File: rtl/cdc_axi_burst_ram_if.sv
// AXI4 burst slave to a simple word-addressed synchronous RAM port, with independent write/read FSMs.
// Optional macro BURST_WRAP_EN adds WRAP burst support; without it WRAP bursts behave as INCR.
//  WR_IDLE  | waiting for AW          RD_IDLE  | waiting for AR
//  WR_DATA  | accepting W beats       RD_FETCH | ram_re high for the current beat
//  WR_RESP  | presenting B            RD_WAIT  | RAM data arriving
//                                     RD_DATA  | beat presented on R until RREADY
module cdc_axi_burst_ram_if #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int RAM_AW             = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [31:0]                     S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [31:0]                     S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [RAM_AW-1:0]               ram_waddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ram_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] ram_we,
  output logic [RAM_AW-1:0]               ram_raddr,
  output logic                            ram_re,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   ram_rdata
);

  localparam int AW = RAM_AW + 2;  // byte address width that reaches the RAM

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_WAIT, RD_DATA} rd_state_t;

`ifdef BURST_WRAP_EN
  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                                input logic [7:0] ln, input logic [1:0] bt);
    logic [AW-1:0] nxt;
    logic [AW-1:0] msk;
    nxt = a + (AW'(1) << sz);
    msk = ((AW'(ln) + AW'(1)) << sz) - AW'(1);
    if (bt == 2'b00) nxt = a;
    else if (bt == 2'b10) nxt = (a & ~msk) | (nxt & msk);
    return nxt;
  endfunction
`else
  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                                input logic [1:0] bt);
    return (bt == 2'b00) ? a : a + (AW'(1) << sz);
  endfunction
`endif

  wr_state_t r_wr_state, w_wr_next;
  rd_state_t r_rd_state, w_rd_next;

  logic [C_S_AXI_ID_WIDTH-1:0] r_wid, r_rid, r_bid, r_rid_out;
  logic [AW-1:0] r_waddr, r_raddr, w_waddr_nxt, w_raddr_nxt;
  logic [7:0] r_wlen, r_rlen, r_wcnt, r_rcnt;
  logic [2:0] r_wsize, r_rsize;
  logic [1:0] r_wburst, r_rburst, r_bresp;
  logic r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_rlast, r_re;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, r_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] r_we;
  logic [RAM_AW-1:0] r_ram_waddr, r_ram_raddr;
  logic w_aw_hs, w_w_hs, w_w_end, w_b_hs, w_ar_hs, w_r_hs;
  logic w_unused;

  assign w_unused = ^{S_AXI_AWADDR[31:AW], S_AXI_ARADDR[31:AW]};

`ifdef BURST_WRAP_EN
  assign w_waddr_nxt = f_next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
  assign w_raddr_nxt = f_next_addr(r_raddr, r_rsize, r_rlen, r_rburst);
`else
  assign w_waddr_nxt = f_next_addr(r_waddr, r_wsize, r_wburst);
  assign w_raddr_nxt = f_next_addr(r_raddr, r_rsize, r_rburst);
`endif

  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID & r_wready;
  assign w_w_end = w_w_hs & (S_AXI_WLAST | (r_wcnt == r_wlen));
  assign w_b_hs  = r_bvalid & S_AXI_BREADY;
  assign w_ar_hs = S_AXI_ARVALID & r_arready;
  assign w_r_hs  = r_rvalid & S_AXI_RREADY;

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (w_aw_hs) w_wr_next = WR_DATA;
      WR_DATA: if (w_w_end) w_wr_next = WR_RESP;
      WR_RESP: if (w_b_hs)  w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_wr_state <= WR_IDLE;
      r_awready <= 1'b1; r_wready <= 1'b0; r_bvalid <= 1'b0; r_bresp <= 2'b00;
      r_bid <= '0; r_wid <= '0; r_waddr <= '0; r_wlen <= '0; r_wsize <= '0;
      r_wburst <= '0; r_wcnt <= '0; r_we <= '0; r_wdata <= '0; r_ram_waddr <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      r_we <= '0;
      if (w_aw_hs) begin
        r_wid <= S_AXI_AWID; r_waddr <= S_AXI_AWADDR[AW-1:0]; r_wlen <= S_AXI_AWLEN;
        r_wsize <= S_AXI_AWSIZE; r_wburst <= S_AXI_AWBURST; r_wcnt <= '0;
        r_awready <= 1'b0; r_wready <= 1'b1;
      end
      if (w_w_hs) begin
        r_we <= S_AXI_WSTRB; r_wdata <= S_AXI_WDATA; r_ram_waddr <= r_waddr[AW-1:2];
        r_waddr <= w_waddr_nxt; r_wcnt <= r_wcnt + 8'd1;
      end
      if (w_w_end) begin
        // an early WLAST or a missing WLAST both flag the burst as malformed
        r_wready <= 1'b0; r_bvalid <= 1'b1; r_bid <= r_wid;
        r_bresp <= (S_AXI_WLAST && (r_wcnt == r_wlen)) ? 2'b00 : 2'b10;
      end
      if (w_b_hs) begin
        r_bvalid <= 1'b0; r_awready <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE:  if (w_ar_hs) w_rd_next = RD_FETCH;
      RD_FETCH: w_rd_next = RD_WAIT;
      RD_WAIT:  w_rd_next = RD_DATA;
      RD_DATA:  if (w_r_hs) w_rd_next = r_rlast ? RD_IDLE : RD_FETCH;
      default:  w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rd_state <= RD_IDLE;
      r_arready <= 1'b1; r_rvalid <= 1'b0; r_rlast <= 1'b0; r_rdata <= '0;
      r_rid_out <= '0; r_rid <= '0; r_raddr <= '0; r_rlen <= '0; r_rsize <= '0;
      r_rburst <= '0; r_rcnt <= '0; r_re <= 1'b0; r_ram_raddr <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      r_re <= 1'b0;
      // ram_re is registered on entry so it is high during the RD_FETCH cycle
      if (w_ar_hs) begin
        r_rid <= S_AXI_ARID; r_raddr <= S_AXI_ARADDR[AW-1:0]; r_rlen <= S_AXI_ARLEN;
        r_rsize <= S_AXI_ARSIZE; r_rburst <= S_AXI_ARBURST; r_rcnt <= '0;
        r_arready <= 1'b0; r_re <= 1'b1; r_ram_raddr <= S_AXI_ARADDR[AW-1:2];
      end
      if (r_rd_state == RD_WAIT) begin
        r_rdata <= ram_rdata; r_rvalid <= 1'b1; r_rid_out <= r_rid;
        r_rlast <= (r_rcnt == r_rlen);
      end
      if (w_r_hs) begin
        r_rvalid <= 1'b0; r_rlast <= 1'b0;
        if (r_rlast) begin
          r_arready <= 1'b1;
        end else begin
          r_raddr <= w_raddr_nxt; r_rcnt <= r_rcnt + 8'd1;
          r_re <= 1'b1; r_ram_raddr <= w_raddr_nxt[AW-1:2];
        end
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BID     = r_bid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RID     = r_rid_out;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RLAST   = r_rlast;
  assign S_AXI_RVALID  = r_rvalid;
  assign ram_waddr     = r_ram_waddr;
  assign ram_wdata     = r_wdata;
  assign ram_we        = r_we;
  assign ram_raddr     = r_ram_raddr;
  assign ram_re        = r_re;

endmodule

// File: tb/tb_cdc_axi_burst_ram_if.sv
// Directed bench for cdc_axi_burst_ram_if with a behavioural RAM; inputs driven and outputs sampled on negedge.
module tb_cdc_axi_burst_ram_if;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:0] awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata, ram_wdata, ram_rdata;
  logic [7:0] awlen = '0, arlen = '0;
  logic [2:0] awsize = 3'd2, arsize = 3'd2;
  logic [1:0] awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic [3:0] wstrb = 4'hF, ram_we;
  logic awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rlast, rvalid, ram_re;
  logic [9:0] ram_waddr, ram_raddr;

  int n_total = 0;
  int n_bad = 0;
  int re_cnt = 0;
  logic [31:0] mem [0:1023];
  logic [9:0]  wl_a[$];
  logic [31:0] wl_d[$];
  logic [3:0]  wl_s[$];

  cdc_axi_burst_ram_if dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  // behavioural RAM: 1-cycle read latency, read returns old data on same-cycle write
  always @(posedge clk) begin
    if (ram_re) begin
      ram_rdata <= mem[ram_raddr];
      re_cnt <= re_cnt + 1;
    end
    if (ram_we != 4'h0) begin
      for (int k = 0; k < 4; k++)
        if (ram_we[k]) mem[ram_waddr][8*k +: 8] <= ram_wdata[8*k +: 8];
      wl_a.push_back(ram_waddr);
      wl_d.push_back(ram_wdata);
      wl_s.push_back(ram_we);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_aw(input logic id, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    int t = 0;
    awid = id; awaddr = a; awlen = l; awsize = 3'd2; awburst = b; awvalid = 1'b1;
    while (!awready && t < 100) begin @(negedge clk); t++; end
    chk("aw_ready", {31'd0, awready}, 1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic last);
    int t = 0;
    wdata = d; wstrb = 4'hF; wlast = last; wvalid = 1'b1;
    while (!wready && t < 100) begin @(negedge clk); t++; end
    chk("w_ready", {31'd0, wready}, 1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wr_burst(input logic id, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic [31:0] base, input int nb, input int last_at);
    send_aw(id, a, l, b);
    for (int i = 0; i < nb; i++) send_w(base + i, i == last_at);
  endtask

  task automatic wait_b(input int hold, input logic exp_id, input logic [1:0] exp_resp);
    int t = 0;
    while (!bvalid && t < 100) begin @(negedge clk); t++; end
    chk("bvalid", {31'd0, bvalid}, 1);
    chk("bresp", {30'd0, bresp}, {30'd0, exp_resp});
    chk("bid", {31'd0, bid}, {31'd0, exp_id});
    repeat (hold) begin @(negedge clk); chk("bvalid_hold", {31'd0, bvalid}, 1); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_clr", {31'd0, bvalid}, 0);
    chk("awready_back", {31'd0, awready}, 1);
  endtask

  task automatic chk_wlog(input int start, input int k, input logic [9:0] a, input logic [31:0] d);
    if (wl_a.size() <= start + k) begin
      chk("wlog_missing", wl_a.size(), start + k + 1);
    end else begin
      chk("wlog_addr", {22'd0, wl_a[start+k]}, {22'd0, a});
      chk("wlog_data", wl_d[start+k], d);
      chk("wlog_strb", {28'd0, wl_s[start+k]}, 32'hF);
    end
  endtask

  task automatic send_ar(input logic id, input logic [31:0] a, input logic [7:0] l);
    int t = 0;
    arid = id; araddr = a; arlen = l; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    while (!arready && t < 100) begin @(negedge clk); t++; end
    chk("ar_ready", {31'd0, arready}, 1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic rd_collect(input int nb, input int stall_at, input int stall_n,
                            input logic [31:0] base, input logic exp_id);
    int re0 = re_cnt;
    for (int i = 0; i < nb; i++) begin
      int t = 0;
      while (!rvalid && t < 100) begin @(negedge clk); t++; end
      chk("rvalid", {31'd0, rvalid}, 1);
      chk("rdata", rdata, base + i);
      chk("rlast", {31'd0, rlast}, (i == nb - 1) ? 1 : 0);
      chk("rresp", {30'd0, rresp}, 0);
      chk("rid", {31'd0, rid}, {31'd0, exp_id});
      if (i == stall_at) begin
        repeat (stall_n) begin
          @(negedge clk);
          chk("stall_rvalid", {31'd0, rvalid}, 1);
          chk("stall_rdata", rdata, base + i);
          chk("stall_rlast", {31'd0, rlast}, (i == nb - 1) ? 1 : 0);
        end
        chk("stall_re_cnt", re_cnt - re0, i + 1);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
    chk("rvalid_clr", {31'd0, rvalid}, 0);
    chk("arready_back", {31'd0, arready}, 1);
    chk("re_total", re_cnt - re0, nb);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 1);
    chk("rst_arready", {31'd0, arready}, 1);
    chk("rst_wready", {31'd0, wready}, 0);
    chk("rst_bvalid", {31'd0, bvalid}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_rlast", {31'd0, rlast}, 0);
    chk("rst_resp", {28'd0, bresp, rresp}, 0);
    chk("rst_ids", {30'd0, bid, rid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_ctl", {27'd0, ram_we, ram_re}, 0);
    chk("rst_ram_addr", {12'd0, ram_waddr, ram_raddr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: 5-beat INCR write at 0x100
    s = wl_a.size();
    wr_burst(1'b1, 32'h100, 8'd4, 2'b01, 32'h12345678, 5, 4);
    wait_b(0, 1'b1, 2'b00);
    chk("t1_nwr", wl_a.size() - s, 5);
    for (int i = 0; i < 5; i++) chk_wlog(s, i, 10'h40 + 10'(i), 32'h12345678 + i);

    // T2: read it back
    send_ar(1'b1, 32'h100, 8'd4);
    rd_collect(5, -1, 0, 32'h12345678, 1'b1);

    // T3: len 3 with WLAST on beat 2 -> two writes and SLVERR
    s = wl_a.size();
    wr_burst(1'b0, 32'h300, 8'd3, 2'b01, 32'hBEEF0000, 2, 1);
    chk("t3_wready", {31'd0, wready}, 0);
    wait_b(0, 1'b0, 2'b10);
    chk("t3_nwr", wl_a.size() - s, 2);
    chk_wlog(s, 0, 10'hC0, 32'hBEEF0000);
    chk_wlog(s, 1, 10'hC1, 32'hBEEF0001);

    // T4: RREADY held low 20 cycles on beat 3
    send_ar(1'b0, 32'h100, 8'd4);
    rd_collect(5, 2, 20, 32'h12345678, 1'b0);

    // T5: concurrent single-beat write and read, B held 5 cycles
    s = wl_a.size();
    fork
      begin
        wr_burst(1'b0, 32'h200, 8'd0, 2'b01, 32'hA5A50000, 1, 0);
        wait_b(5, 1'b0, 2'b00);
      end
      begin
        send_ar(1'b1, 32'h300, 8'd0);
        rd_collect(1, -1, 0, 32'hBEEF0000, 1'b1);
      end
    join
    chk("t5_nwr", wl_a.size() - s, 1);
    chk_wlog(s, 0, 10'h80, 32'hA5A50000);

    // T6: reset pulse during a write beat, then a clean burst
    send_aw(1'b1, 32'h280, 8'd3, 2'b01);
    send_w(32'h55550000, 1'b0);
    wdata = 32'h55550001; wvalid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("t6_awready", {31'd0, awready}, 1);
    chk("t6_wready", {31'd0, wready}, 0);
    chk("t6_bvalid", {31'd0, bvalid}, 0);
    chk("t6_arready", {31'd0, arready}, 1);
    chk("t6_rvalid", {31'd0, rvalid}, 0);
    chk("t6_ram_we", {28'd0, ram_we}, 0);
    chk("t6_bid", {31'd0, bid}, 0);
    wvalid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    s = wl_a.size();
    wr_burst(1'b1, 32'h280, 8'd1, 2'b01, 32'h66660000, 2, 1);
    wait_b(0, 1'b1, 2'b00);
    chk("t6_nwr", wl_a.size() - s, 2);
    chk_wlog(s, 0, 10'hA0, 32'h66660000);
    chk_wlog(s, 1, 10'hA1, 32'h66660001);

`ifdef BURST_WRAP_EN
    s = wl_a.size();
    wr_burst(1'b0, 32'h10C, 8'd3, 2'b10, 32'h77770000, 4, 3);
    wait_b(0, 1'b0, 2'b00);
    chk_wlog(s, 0, 10'h43, 32'h77770000);
    chk_wlog(s, 1, 10'h40, 32'h77770001);
    chk_wlog(s, 2, 10'h41, 32'h77770002);
    chk_wlog(s, 3, 10'h42, 32'h77770003);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
